spio_spinnaker_link_sync_rx_fifo: RTL and testbench

Parametrised, fully synchronous successor to the SpiNNaker link 2-of-7 receive buffer. It samples the asynchronous NRZ 2-of-7 link through an internal synchroniser and detects symbol completion by counting transitions. Completed symbols are stored as RTZ codes in a configurable-depth FIFO, and each accepted symbol is acknowledged with an ack toggle. The block feeds the packet deserializer over a valid/ready interface and sits between the SpiNNaker link pins and that deserializer.

---
 rtl/spio_spinnaker_link_sync_rx_fifo_if.sv | 9 +
 rtl/spio_spinnaker_link_sync_rx_fifo.sv | 130 +++++++++++++
 tb/tb_spio_spinnaker_link_sync_rx_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spio_spinnaker_link_sync_rx_fifo_if.sv
// Flit handshake between the SpiNNaker link receive FIFO and the packet deserializer.
interface spio_spinnaker_link_sync_rx_fifo_if;
    logic [6:0] flt_data_2of7;
    logic       flt_vld;
    logic       flt_rdy;

    modport master (output flt_data_2of7, output flt_vld, input flt_rdy);
    modport slave  (input flt_data_2of7, input flt_vld, output flt_rdy);
endinterface

// File: rtl/spio_spinnaker_link_sync_rx_fifo.sv
// Synchronous 2-of-7 NRZ link receiver: synchronise, decode transitions, buffer RTZ symbols, ack each.
// Optional error counter enabled by defining SPIO_SL_RX_ERR_CNT_EN.
module spio_spinnaker_link_sync_rx_fifo #(
    parameter int BUFF_DEPTH_LOG2 = 2,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       CLK_IN,
    input  logic                       RESET_IN,
    input  logic [6:0]                 SL_DATA_2OF7_IN,
    output logic                       SL_ACK_OUT,
    spio_spinnaker_link_sync_rx_fifo_if.master flt,
    output logic [BUFF_DEPTH_LOG2:0]   occupancy
`ifdef SPIO_SL_RX_ERR_CNT_EN
    ,
    input  logic                       err_cnt_clr,
    output logic [15:0]                err_cnt
`endif
);

    localparam int DEPTH = 1 << BUFF_DEPTH_LOG2;
    localparam logic [BUFF_DEPTH_LOG2:0] W_DEPTH = DEPTH[BUFF_DEPTH_LOG2:0];

    logic [6:0]                 r_sync [SYNC_STAGES];
    logic [6:0]                 r_old;
    logic [6:0]                 r_mem [DEPTH];
    logic [BUFF_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [BUFF_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [BUFF_DEPTH_LOG2:0]   r_occ;
    logic                       r_vld;
    logic                       r_ack;
    logic                       r_live;

    logic [6:0] w_rtz;
    logic [2:0] w_ones;
    logic       w_new;
    logic       w_pop;
    logic       w_full;
    logic       w_push;

    assign w_rtz = r_sync[SYNC_STAGES-1] ^ r_old;

    always_comb begin
        w_ones = 3'd0;
        for (int i = 0; i < 7; i++) begin
            w_ones = w_ones + {2'b00, w_rtz[i]};
        end
    end

    // A lone transition is inter-wire skew; wait for the second wire before accepting.
    assign w_new  = (w_ones >= 3'd2);
    assign w_pop  = r_vld && flt.flt_rdy;
    assign w_full = (r_occ == W_DEPTH);
    assign w_push = r_live && w_new && (!w_full || w_pop);

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 7'h00;
            end
            r_old    <= 7'h00;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_vld    <= 1'b0;
            r_ack    <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_sync[0] <= SL_DATA_2OF7_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end

            // First edge out of reset only raises ack to tell the transmitter we are alive.
            if (!r_live) begin
                r_live <= 1'b1;
                r_ack  <= 1'b1;
            end

            if (w_push) begin
                r_old    <= r_sync[SYNC_STAGES-1];
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_ack    <= ~r_ack;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10: begin
                    r_occ <= r_occ + 1'b1;
                    r_vld <= 1'b1;
                end
                2'b01: begin
                    r_occ <= r_occ - 1'b1;
                    r_vld <= (r_occ != 1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (w_push && !RESET_IN) begin
            r_mem[r_wr_ptr] <= w_rtz;
        end
    end

    assign flt.flt_data_2of7 = r_vld ? r_mem[r_rd_ptr] : 7'h00;
    assign flt.flt_vld       = r_vld;
    assign occupancy         = r_occ;
    assign SL_ACK_OUT        = r_ack;

`ifdef SPIO_SL_RX_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // 7'b1100000 is the legal EOP code; everything else beyond two transitions is an error.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN || err_cnt_clr) begin
            r_err_cnt <= 16'h0000;
        end else if (w_push && (w_ones > 3'd2) && (w_rtz != 7'b1100000)
                     && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'h0001;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_spio_spinnaker_link_sync_rx_fifo.sv
// Scoreboard bench for the SpiNNaker link receive FIFO: bench transmitter, random-ready consumer.
module tb_spio_spinnaker_link_sync_rx_fifo;

    localparam int LOG2 = 2;
    localparam int SYNC = 2;
    localparam int DEPTH = 1 << LOG2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      link_drv = 7'h00;
    logic            ack;
    logic [LOG2:0]   occ;
    logic            rdy_drv = 1'b0;
`ifdef SPIO_SL_RX_ERR_CNT_EN
    logic            err_clr = 1'b0;
    logic [15:0]     err_cnt;
`endif

    spio_spinnaker_link_sync_rx_fifo_if flt_if ();
    assign flt_if.flt_rdy = rdy_drv;

    spio_spinnaker_link_sync_rx_fifo #(
        .BUFF_DEPTH_LOG2 (LOG2),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .CLK_IN          (clk),
        .RESET_IN        (rst),
        .SL_DATA_2OF7_IN (link_drv),
        .SL_ACK_OUT      (ack),
        .flt             (flt_if),
        .occupancy       (occ)
`ifdef SPIO_SL_RX_ERR_CNT_EN
        ,
        .err_cnt_clr     (err_clr),
        .err_cnt         (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] q[$];
    logic       last_ack = 1'b0;
    logic       rdy_random = 1'b0;
    logic       rdy_hold   = 1'b0;
    int         pulse_req  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Consumer: choose ready for the coming edge, then score any pop it will cause.
    logic       nr;
    logic       prev_stall = 1'b0;
    logic [6:0] prev_data  = 7'h00;
    logic [6:0] exp_d;
    always @(negedge clk) begin
        if (rdy_random) nr = ($urandom_range(0, 1) == 1);
        else if (pulse_req > 0) begin
            nr = 1'b1;
            pulse_req--;
        end else nr = rdy_hold;
        rdy_drv = nr;
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_vld", {31'b0, flt_if.flt_vld}, 32'd1);
                chk("stall_data", {25'b0, flt_if.flt_data_2of7}, {25'b0, prev_data});
            end
            if (flt_if.flt_vld === 1'b1 && nr) begin
                if (q.size() == 0) chk("pop_nonempty", 32'd0, 32'd1);
                else begin
                    exp_d = q.pop_front();
                    chk("rx_data", {25'b0, flt_if.flt_data_2of7}, {25'b0, exp_d});
                end
            end
            prev_stall = (flt_if.flt_vld === 1'b1) && !nr;
            prev_data  = flt_if.flt_data_2of7;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic drive_sym(input logic [6:0] code);
        @(negedge clk);
        link_drv = link_drv ^ code;
        q.push_back(code);
    endtask

    task automatic wait_ack(input string tag, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack !== last_ack) got = 1'b1;
        end
        chk(tag, {31'b0, got}, 32'd1);
        last_ack = ack;
    endtask

    task automatic send_sym(input logic [6:0] code);
        drive_sym(code);
        wait_ack("ack", 100);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && (q.size() != 0 || occ != 0); i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, q.size(), 32'd0);
        chk({tag, "_occ"}, {29'b0, occ}, 32'd0);
    endtask

    function automatic logic [6:0] rand_code();
        int b0, b1;
        logic [6:0] c;
        b0 = $urandom_range(0, 6);
        b1 = $urandom_range(0, 5);
        if (b1 >= b0) b1++;
        c = 7'h00;
        c[b0] = 1'b1;
        c[b1] = 1'b1;
        return c;
    endfunction

    initial begin
        int tog;
        logic pa;

        // Reset and reset-exit ack
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_vld", {31'b0, flt_if.flt_vld}, 32'd0);
        chk("rst_occ", {29'b0, occ}, 32'd0);
        chk("rst_data", {25'b0, flt_if.flt_data_2of7}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("exit_ack", {31'b0, ack}, 32'd1);
        chk("exit_vld", {31'b0, flt_if.flt_vld}, 32'd0);
        chk("exit_occ", {29'b0, occ}, 32'd0);
        last_ack = ack;

        // Single symbol latency
        drive_sym(7'h11);
        for (int i = 0; i < SYNC; i++) begin
            @(posedge clk);
            #1;
            chk("lat_early_vld", {31'b0, flt_if.flt_vld}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("lat_vld", {31'b0, flt_if.flt_vld}, 32'd1);
        chk("lat_ack", {31'b0, ack}, {31'b0, ~last_ack});
        chk("lat_data", {25'b0, flt_if.flt_data_2of7}, 32'h11);
        chk("lat_occ", {29'b0, occ}, 32'd1);
        last_ack = ack;
        pulse_req = 1;
        wait_drain("single_drain");

        // Skewed wires: bit0 one cycle ahead of bit4
        @(negedge clk);
        link_drv = link_drv ^ 7'h01;
        @(negedge clk);
        link_drv = link_drv ^ 7'h10;
        q.push_back(7'h11);
        tog = 0;
        pa = ack;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ack !== pa) tog++;
            pa = ack;
        end
        chk("skew_toggles", tog, 32'd1);
        chk("skew_occ", {29'b0, occ}, 32'd1);
        last_ack = ack;
        rdy_hold = 1'b1;
        wait_drain("skew_drain");

        // Full FIFO stall and release by a single pop
        rdy_hold = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_sym(7'h03 << i);
        chk("full_occ", {29'b0, occ}, DEPTH);
        drive_sym(7'h60);
        repeat (8) @(posedge clk);
        #1;
        chk("full_noack", {31'b0, ack}, {31'b0, last_ack});
        chk("full_occ_hold", {29'b0, occ}, DEPTH);
        pulse_req = 1;
        for (int i = 0; i < 20 && rdy_drv !== 1'b1; i++) @(negedge clk);
        chk("pulse_seen", {31'b0, rdy_drv}, 32'd1);
        @(posedge clk);
        #1;
        chk("release_ack", {31'b0, ack}, {31'b0, ~last_ack});
        chk("release_occ", {29'b0, occ}, DEPTH);
        last_ack = ack;
        rdy_hold = 1'b1;
        wait_drain("full_drain");

`ifdef SPIO_SL_RX_ERR_CNT_EN
        send_sym(7'h07);
        send_sym(7'h07);
        send_sym(7'h60);
        wait_drain("err_drain");
        chk("err_cnt", {16'b0, err_cnt}, 32'd2);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clr", {16'b0, err_cnt}, 32'd0);
`endif

        // Random backpressure over 100 symbols
        rdy_random = 1'b1;
        for (int i = 0; i < 100; i++) send_sym(rand_code());
        wait_drain("rand_drain");
        rdy_random = 1'b0;

        // Reset with symbols stored
        @(posedge clk);
        #1;
        rdy_hold = 1'b0;
        for (int i = 0; i < 3; i++) send_sym(rand_code());
        chk("pre_rst_occ", {29'b0, occ}, 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        link_drv = 7'h00;
        q.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_occ", {29'b0, occ}, 32'd0);
        chk("mid_rst_vld", {31'b0, flt_if.flt_vld}, 32'd0);
        chk("mid_rst_ack", {31'b0, ack}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("re_exit_ack", {31'b0, ack}, 32'd1);
        last_ack = ack;
        rdy_hold = 1'b1;
        send_sym(7'h41);
        wait_drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
